// File: rtl/cep_uart_tx_if.sv
// Parallel-in / serial-out handshake bundle for the CEP byte transmitter.
interface cep_uart_tx_if;
    logic       Tx_start;
    logic       load;
    logic [7:0] data;
    logic       Tx;

    // Producer side: drives the byte and requests, watches the line
    modport master (
        output Tx_start,
        output load,
        output data,
        input  Tx
    );

    // Transmitter side
    modport slave (
        input  Tx_start,
        input  load,
        input  data,
        output Tx
    );
endinterface

// File: rtl/cep_uart_tx.sv
// Byte-wide UART-style transmitter: start, 8 data bits LSB first,
// optional even parity, stop. Tx is registered and idles high.
module cep_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter bit          PARITY_EN    = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    cep_uart_tx_if.slave bus
);

    localparam int unsigned BAUD_W = 16;
    localparam int unsigned BIT_W  = 3;
    localparam int unsigned BYTE_W = 8;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(BYTE_W - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]        state_q,  state_d;
    logic [BAUD_W-1:0] baud_q,   baud_d;
    logic [BIT_W-1:0]  bit_q,    bit_d;
    logic [BYTE_W-1:0] shift_q,  shift_d;
    logic [BYTE_W-1:0] hold_q,   hold_d;
    logic              par_q,    par_d;
    logic              tx_q,     tx_d;
    logic              baud_done;

    assign baud_done = (baud_q == BAUD_LAST);

    // State and datapath registers; reset parks the line high
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            hold_q  <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            hold_q  <= hold_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    // Next-state, counters and the line value for the coming cycle
    always_comb begin
        state_d = state_q;
        baud_d  = baud_done ? '0 : baud_q + BAUD_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        hold_d  = bus.load ? bus.data : hold_q;
        tx_d    = 1'b1;

        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (bus.Tx_start) begin
                    state_d = S_START;
                    shift_d = hold_q;
                    par_d   = ^hold_q;
                end
            end
            S_START: begin
                if (baud_done) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (baud_done) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        state_d = PARITY_EN ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (baud_done) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (baud_done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
            end
        endcase

        // Line value follows the state being entered so Tx is a clean flop
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
    end

    assign bus.Tx = tx_q;

endmodule

// File: tb/tb_cep_uart_tx.sv
// Scoreboard bench for cep_uart_tx: three instances cover
// (1 clk/bit, parity), (4 clk/bit, parity) and (1 clk/bit, no parity).
module tb_cep_uart_tx;

    logic clk;
    logic reset;

    int n_checks = 0;
    int n_fail   = 0;

    bit q_a[$];
    bit q_b[$];
    bit q_c[$];

    cep_uart_tx_if if_a ();
    cep_uart_tx_if if_b ();
    cep_uart_tx_if if_c ();

    cep_uart_tx #(.CLKS_PER_BIT(1), .PARITY_EN(1'b1)) dut_a (.clk(clk), .reset(reset), .bus(if_a));
    cep_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1)) dut_b (.clk(clk), .reset(reset), .bus(if_b));
    cep_uart_tx #(.CLKS_PER_BIT(1), .PARITY_EN(1'b0)) dut_c (.clk(clk), .reset(reset), .bus(if_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Line monitors: one expected bit per cycle, sampled mid-cycle
    always @(negedge clk) begin
        bit e;
        if (q_a.size() > 0) begin
            e = q_a.pop_front();
            check_eq("tx_a", 32'(if_a.Tx), 32'(e));
        end
        if (q_b.size() > 0) begin
            e = q_b.pop_front();
            check_eq("tx_b", 32'(if_b.Tx), 32'(e));
        end
        if (q_c.size() > 0) begin
            e = q_c.pop_front();
            check_eq("tx_c", 32'(if_c.Tx), 32'(e));
        end
    end

    function automatic int cpb(input int sel);
        return (sel == 1) ? 4 : 1;
    endfunction

    function automatic bit par_en(input int sel);
        return (sel != 2);
    endfunction

    function automatic int qsize(input int sel);
        case (sel)
            0:       return q_a.size();
            1:       return q_b.size();
            default: return q_c.size();
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int sel, input logic st, input logic ld, input logic [7:0] d);
        case (sel)
            0:       begin if_a.Tx_start = st; if_a.load = ld; if_a.data = d; end
            1:       begin if_b.Tx_start = st; if_b.load = ld; if_b.data = d; end
            default: begin if_c.Tx_start = st; if_c.load = ld; if_c.data = d; end
        endcase
    endtask

    task automatic push_n(input int sel, input bit v, input int n);
        for (int i = 0; i < n; i++) begin
            case (sel)
                0:       q_a.push_back(v);
                1:       q_b.push_back(v);
                default: q_c.push_back(v);
            endcase
        end
    endtask

    // Expected line for one whole frame of byte d
    task automatic push_frame(input int sel, input logic [7:0] d);
        int c;
        c = cpb(sel);
        push_n(sel, 1'b0, c);
        for (int i = 0; i < 8; i++) push_n(sel, d[i], c);
        if (par_en(sel)) push_n(sel, ^d, c);
        push_n(sel, 1'b1, c);
    endtask

    task automatic drain(input int sel);
        int n;
        n = 0;
        while (qsize(sel) > 0 && n < 2000) begin
            step();
            n++;
        end
        if (qsize(sel) > 0) check_eq("drain_timeout", 32'(qsize(sel)), 32'd0);
    endtask

    // Optional load, then Tx_start held for 'hold' cycles; expects byte exp_d
    task automatic do_frame(input int sel, input bit do_load, input logic [7:0] d,
                            input logic [7:0] exp_d, input int hold);
        if (do_load) begin
            step();
            set_in(sel, 1'b0, 1'b1, d);
            push_n(sel, 1'b1, 1);
        end
        step();
        set_in(sel, 1'b1, 1'b0, d);
        push_n(sel, 1'b1, 1);
        push_frame(sel, exp_d);
        push_n(sel, 1'b1, 3);
        repeat (hold - 1) step();
        step();
        set_in(sel, 1'b0, 1'b0, d);
        drain(sel);
    endtask

    // Tx_start held high across nf frames: exactly one idle cycle between them
    task automatic run_cont(input int sel, input logic [7:0] d, input int nf);
        int flen;
        flen = cpb(sel) * (par_en(sel) ? 11 : 10);
        step();
        set_in(sel, 1'b0, 1'b1, d);
        push_n(sel, 1'b1, 1);
        step();
        set_in(sel, 1'b1, 1'b0, d);
        push_n(sel, 1'b1, 1);
        for (int k = 0; k < nf; k++) begin
            push_frame(sel, d);
            if (k < nf - 1) push_n(sel, 1'b1, 1);
        end
        push_n(sel, 1'b1, 3);
        repeat ((nf - 1) * (flen + 1) + 2) step();
        set_in(sel, 1'b0, 1'b0, d);
        drain(sel);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        for (int s = 0; s < 3; s++) set_in(s, 1'b0, 1'b0, 8'h00);

        // Reset held with random inputs: line must stay high
        for (int i = 0; i < 8; i++) begin
            step();
            for (int s = 0; s < 3; s++) set_in(s, 1'($urandom), 1'($urandom), 8'($urandom));
            #2;
            check_eq("rst_tx_a", 32'(if_a.Tx), 32'd1);
            check_eq("rst_tx_b", 32'(if_b.Tx), 32'd1);
            check_eq("rst_tx_c", 32'(if_c.Tx), 32'd1);
        end
        for (int s = 0; s < 3; s++) set_in(s, 1'b0, 1'b0, 8'h00);
        step();
        reset = 1'b1;
        step();
        check_eq("idle_tx_a", 32'(if_a.Tx), 32'd1);
        check_eq("idle_tx_b", 32'(if_b.Tx), 32'd1);
        check_eq("idle_tx_c", 32'(if_c.Tx), 32'd1);

        // Basic frames at 1 clk/bit with parity
        do_frame(0, 1'b1, 8'h0F, 8'h0F, 2);
        do_frame(0, 1'b1, 8'h01, 8'h01, 1);
        do_frame(0, 1'b1, 8'hFF, 8'hFF, 1);

        // 4 clocks per bit
        do_frame(1, 1'b1, 8'hA5, 8'hA5, 1);
        do_frame(1, 1'b1, 8'h3E, 8'h3E, 3);

        // Load mid-frame only affects the next frame
        step();
        set_in(0, 1'b0, 1'b1, 8'h0F);
        push_n(0, 1'b1, 1);
        step();
        set_in(0, 1'b1, 1'b0, 8'h0F);
        push_n(0, 1'b1, 1);
        push_frame(0, 8'h0F);
        push_n(0, 1'b1, 2);
        step();
        set_in(0, 1'b0, 1'b0, 8'h0F);
        repeat (3) step();
        set_in(0, 1'b0, 1'b1, 8'hAA);
        step();
        set_in(0, 1'b0, 1'b0, 8'h00);
        drain(0);
        do_frame(0, 1'b0, 8'h00, 8'hAA, 1);

        // Load and start together in IDLE: old byte goes out, new one is kept
        step();
        set_in(0, 1'b1, 1'b1, 8'h3C);
        push_n(0, 1'b1, 1);
        push_frame(0, 8'hAA);
        push_n(0, 1'b1, 2);
        step();
        set_in(0, 1'b0, 1'b0, 8'h00);
        drain(0);
        do_frame(0, 1'b0, 8'h00, 8'h3C, 1);

        // Continuous start
        run_cont(0, 8'h55, 3);
        run_cont(1, 8'h81, 2);

        // No-parity instance
        do_frame(2, 1'b1, 8'h96, 8'h96, 1);
        do_frame(2, 1'b1, 8'h01, 8'h01, 2);
        run_cont(2, 8'hC7, 3);

        // Asynchronous reset in the middle of an all-zero frame
        step();
        set_in(0, 1'b0, 1'b1, 8'h00);
        step();
        set_in(0, 1'b1, 1'b0, 8'h00);
        step();
        set_in(0, 1'b0, 1'b0, 8'h00);
        repeat (4) step();
        check_eq("pre_rst_tx_low", 32'(if_a.Tx), 32'd0);
        #2;
        reset = 1'b0;
        #1;
        check_eq("async_rst_tx", 32'(if_a.Tx), 32'd1);
        step();
        check_eq("in_rst_tx", 32'(if_a.Tx), 32'd1);
        reset = 1'b1;
        push_n(0, 1'b1, 4);
        drain(0);
        do_frame(0, 1'b1, 8'hC3, 8'hC3, 1);

        repeat (3) step();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
